// File: rtl/ssd_scan_controller_pkg.sv
// Shared constants for the seven-segment scan controller: hex glyphs, blank pattern, pin polarity.
// Glyphs are packed abcdefg with segment a in bit 6; a 0 bit lights the segment.
package ssd_scan_controller_pkg;

  localparam logic       SEG_ON    = 1'b0;
  localparam logic       AN_OFF    = 1'b1;
  localparam logic       DP_OFF    = 1'b1;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/ssd_scan_controller_encode.sv
// Hex nibble to active-low seven-segment glyph (the existing ssd_encode table).
module ssd_encode
  import ssd_scan_controller_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ssd_scan_controller.sv
// N-digit multiplexed seven-segment driver with double-buffered digit data, PWM brightness,
// per-digit blink and a frame-done pulse. All pin outputs are registered and active-low.
module ssd_scan_controller
  import ssd_scan_controller_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int PRESCALE_W = 16,
  parameter int BRIGHT_W   = 4,
  parameter int BLINK_W    = 6
) (
  input  logic                  stateClk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     enable,
  input  logic [DIGITS-1:0]     blink,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRESCALE_W-1:0] cnt;
  logic [IDX_W-1:0]      idx;
  logic [BLINK_W-1:0]    blink_cnt;

  // Pending buffer is written by load; active buffer only changes on a frame boundary.
  logic [4*DIGITS-1:0]   pend_dig, act_dig;
  logic [DIGITS-1:0]     pend_dp, pend_en, pend_bl;
  logic [DIGITS-1:0]     act_dp, act_en, act_bl;
  logic                  pend;

  logic                  slot_end, boundary, lit, show;
  logic [3:0]            cur_hex;
  logic [6:0]            cur_seg;

  assign slot_end = &cnt;
  assign boundary = slot_end && (idx == IDX_LAST);

  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (boundary)
        blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // A load landing on the boundary cycle bypasses the pending buffer so it shows from the next idx 0.
  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_en  <= '0;
      pend_bl  <= '0;
      act_dig  <= '0;
      act_dp   <= '0;
      act_en   <= '0;
      act_bl   <= '0;
      pend     <= 1'b0;
    end else if (load && boundary) begin
      act_dig <= digits;
      act_dp  <= dp;
      act_en  <= enable;
      act_bl  <= blink;
      pend    <= 1'b0;
    end else if (load) begin
      pend_dig <= digits;
      pend_dp  <= dp;
      pend_en  <= enable;
      pend_bl  <= blink;
      pend     <= 1'b1;
    end else if (boundary && pend) begin
      act_dig <= pend_dig;
      act_dp  <= pend_dp;
      act_en  <= pend_en;
      act_bl  <= pend_bl;
      pend    <= 1'b0;
    end
  end

  assign cur_hex = act_dig[4*idx +: 4];
  assign lit     = (cnt[PRESCALE_W-1 -: BRIGHT_W] <= brightness);
  assign show    = act_en[idx] && lit && !(act_bl[idx] && blink_cnt[BLINK_W-1]);

  ssd_encode u_encode (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      an         <= {DIGITS{AN_OFF}};
      seg        <= SEG_BLANK;
      dp_n       <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      an         <= show ? ~(DIGITS'(1) << idx) : {DIGITS{AN_OFF}};
      seg        <= show ? cur_seg : SEG_BLANK;
      dp_n       <= show ? ~act_dp[idx] : DP_OFF;
      frame_done <= boundary;
    end
  end

endmodule
